apb_master_if: RTL

- APB3 requester (initiator) that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers toward peripheral slaves such as the I2C register block.
- Sits on the APB side of the AHB-APB bridge.
- Returns read data, PSLVERR and timeout status on a one-cycle response strobe.
- One transfer in flight at a time.

---
 rtl/apb_master_if_pkg.sv | 11 +
 rtl/apb_master_if_wait_timer.sv | 43 ++++
 rtl/apb_master_if.sv | 132 +++++++++++++
 3 files changed

// File: rtl/apb_master_if_pkg.sv
// Shared definitions for the APB3 requester.
// Holds the FSM state encoding used by apb_master_if.
package apb_master_if_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'b00,
        APB_SETUP  = 2'b01,
        APB_ACCESS = 2'b10
    } apb_state_e;

endpackage

// File: rtl/apb_master_if_wait_timer.sv
// Wait-state counter for the APB ACCESS phase.
// Ports:
//   pclk, prst_n : clock, async active-low reset
//   clr_i        : clear counter (entry to SETUP)
//   en_i         : count one wait cycle (ACCESS with pready low)
//   expired_o    : this wait cycle brings the count to TIMEOUT_CYC
module apb_wait_timer #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic pclk,
    input  logic prst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    // Count value before the wait cycle that reaches TIMEOUT_CYC.
    localparam logic [CNT_W-1:0] LAST_WAIT =
        (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT_CYC != 0) && en_i && (cnt_q >= LAST_WAIT);

endmodule

// File: rtl/apb_master_if.sv
// APB3 requester: converts a valid/ready command stream into APB
// SETUP/ACCESS transfers and returns a one-cycle response strobe.
// Ports:
//   pclk, prst_n         : clock, async active-low reset
//   req_*                : command stream (valid/ready, write, addr, wdata)
//   rsp_*                : completion strobe with read data, error, timeout
//   psel..pwdata         : APB requester outputs (all registered)
//   prdata, pready,
//   pslverr              : APB completer inputs
module apb_master_if
    import apb_master_if_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_e        state_q;
    logic              psel_q, penable_q, pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
    logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic              accept, timer_clr, timer_en, timer_expired;

    assign req_ready = (state_q == APB_IDLE);
    assign accept    = req_valid && req_ready;
    assign timer_clr = accept;
    assign timer_en  = (state_q == APB_ACCESS) && !pready;

    apb_wait_timer #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .pclk      (pclk),
        .prst_n    (prst_n),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q       <= APB_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                APB_IDLE: begin
                    if (accept) begin
                        state_q   <= APB_SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        paddr_q   <= req_addr;
                        pwrite_q  <= req_write;
                        if (req_write) begin
                            pwdata_q <= req_wdata;
                        end
                    end
                end
                APB_SETUP: begin
                    state_q   <= APB_ACCESS;
                    penable_q <= 1'b1;
                end
                APB_ACCESS: begin
                    // pready is checked first so it wins over a coincident timeout.
                    if (pready) begin
                        state_q       <= APB_IDLE;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= pwrite_q ? '0 : prdata;
                    end else if (timer_expired) begin
                        state_q       <= APB_IDLE;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                    end
                end
                default: begin
                    state_q   <= APB_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
